// File: rtl/cpu7_csr_ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu7_csr_ex_pkg
// Description : Shared definitions for the CSR execution stage: data and CSR
//               address widths, CSR addresses used by the stage's users,
//               op encodings, FSM state encodings and a small op helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu7_csr_ex_pkg;

  // Data path width (GRLEN) and CSR address width (LSOC1K_CSR_BIT).
  localparam int GRLEN   = 32;
  localparam int CSR_BIT = 14;

  // CSR addresses.
  localparam logic [CSR_BIT-1:0] CSR_CRMD  = 14'h000;
  localparam logic [CSR_BIT-1:0] CSR_EPC   = 14'h006;
  localparam logic [CSR_BIT-1:0] CSR_EBASE = 14'h00c;

  // CSR op encodings; the reserved encoding executes as a plain read.
  typedef enum logic [1:0] {
    CSR_OP_RD   = 2'b00,
    CSR_OP_WR   = 2'b01,
    CSR_OP_XCHG = 2'b10,
    CSR_OP_RSVD = 2'b11
  } csr_op_e;

  // Stage FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_ex_state_e;

  // True for ops that commit a write to the CSR file.
  function automatic logic op_writes(input csr_op_e op);
    return (op == CSR_OP_WR) || (op == CSR_OP_XCHG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu7_csr_wmerge.sv
`default_nettype none
// ============================================================================
// Module      : cpu7_csr_wmerge
// Description : Combinational new-value generator for CSR writes.
//               WR   : new = wdata
//               XCHG : new = (old & ~mask) | (wdata & mask)
//               others pass wdata through (never written).
// Ports       : old_val  - current CSR value
//               wdata    - write data (rd source)
//               mask     - xchg mask (rj)
//               op       - decoded CSR op
//               new_val  - value to write
// Revision    : 1.0 - initial release
// ============================================================================
module cpu7_csr_wmerge
  import cpu7_csr_ex_pkg::*;
(
  input  logic [GRLEN-1:0] old_val,
  input  logic [GRLEN-1:0] wdata,
  input  logic [GRLEN-1:0] mask,
  input  csr_op_e          op,
  output logic [GRLEN-1:0] new_val
);

  always_comb begin
    new_val = wdata;
    if (op == CSR_OP_XCHG) begin
      new_val = (old_val & ~mask) | (wdata & mask);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu7_csr_ex.sv
`default_nettype none
// ============================================================================
// Module      : cpu7_csr_ex
// Description : CSR-instruction execution stage. Accepts one csrrd/csrwr/
//               csrxchg op, reads the old CSR value, optionally writes the
//               (masked) new value, and returns the old value to writeback.
//               FSM: IDLE -> READ -> [WRITE] -> RESP -> IDLE.
// Config      : CPU7_CSR_PLV_CHECK_EN - adds csr_plv input and wb_ipe output;
//               ops accepted with csr_plv != 0 skip the CSR access and
//               respond with wb_ipe=1, wb_data=0.
// Ports       : clk, reset (async, active high)
//               ex_*  : op handshake from EX (valid/ready) + payload, flush
//               csr_* : read/write ports of the CSR register file
//               wb_*  : result handshake to writeback (valid/ready)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu7_csr_ex
  import cpu7_csr_ex_pkg::*;
#(
  parameter int RD_IDX_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [1:0]          ex_op,
  input  logic [CSR_BIT-1:0]  ex_csr_addr,
  input  logic [GRLEN-1:0]    ex_wdata,
  input  logic [GRLEN-1:0]    ex_mask,
  input  logic [RD_IDX_W-1:0] ex_rd_idx,
  input  logic                ex_flush,
`ifdef CPU7_CSR_PLV_CHECK_EN
  input  logic [1:0]          csr_plv,
  output logic                wb_ipe,
`endif
  output logic [CSR_BIT-1:0]  csr_raddr,
  input  logic [GRLEN-1:0]    csr_rdata,
  output logic [CSR_BIT-1:0]  csr_waddr,
  output logic [GRLEN-1:0]    csr_wdata,
  output logic                csr_wen,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RD_IDX_W-1:0] wb_rd_idx,
  output logic [GRLEN-1:0]    wb_data
);

  csr_ex_state_e       r_state;
  csr_op_e             r_op;
  logic [CSR_BIT-1:0]  r_addr;
  logic [GRLEN-1:0]    r_wdata;
  logic [GRLEN-1:0]    r_mask;
  logic [RD_IDX_W-1:0] r_rd_idx;
  logic [GRLEN-1:0]    r_old;
  logic [GRLEN-1:0]    w_new_val;

  // The merge is fed from csr_rdata during READ so the write data can be
  // registered on the same edge that captures r_old; the value equals
  // (r_old & ~mask) | (wdata & mask) as seen in WRITE.
  cpu7_csr_wmerge u_wmerge (
    .old_val (csr_rdata),
    .wdata   (r_wdata),
    .mask    (r_mask),
    .op      (r_op),
    .new_val (w_new_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= CSR_OP_RD;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_rd_idx  <= '0;
      r_old     <= '0;
      ex_ready  <= 1'b1;
      csr_raddr <= '0;
      csr_waddr <= '0;
      csr_wdata <= '0;
      csr_wen   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd_idx <= '0;
      wb_data   <= '0;
`ifdef CPU7_CSR_PLV_CHECK_EN
      wb_ipe    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // ex_ready is always high here, so ex_valid alone is the handshake.
          if (ex_valid && !ex_flush) begin
            r_op     <= csr_op_e'(ex_op);
            r_addr   <= ex_csr_addr;
            r_wdata  <= ex_wdata;
            r_mask   <= ex_mask;
            r_rd_idx <= ex_rd_idx;
            ex_ready <= 1'b0;
`ifdef CPU7_CSR_PLV_CHECK_EN
            if (csr_plv != 2'd0) begin
              // Privilege fault: no CSR access at all, respond directly.
              r_state   <= ST_RESP;
              wb_valid  <= 1'b1;
              wb_ipe    <= 1'b1;
              wb_data   <= '0;
              wb_rd_idx <= ex_rd_idx;
            end else begin
              r_state   <= ST_READ;
              csr_raddr <= ex_csr_addr;
            end
`else
            r_state   <= ST_READ;
            csr_raddr <= ex_csr_addr;
`endif
          end
        end

        ST_READ: begin
          csr_raddr <= '0;
          if (ex_flush) begin
            r_state  <= ST_IDLE;
            ex_ready <= 1'b1;
          end else begin
            r_old <= csr_rdata;
            if (op_writes(r_op)) begin
              r_state   <= ST_WRITE;
              csr_wen   <= 1'b1;
              csr_waddr <= r_addr;
              csr_wdata <= w_new_val;
            end else begin
              r_state   <= ST_RESP;
              wb_valid  <= 1'b1;
              wb_data   <= csr_rdata;
              wb_rd_idx <= r_rd_idx;
            end
          end
        end

        ST_WRITE: begin
          // Flush is ignored once the write has started.
          csr_wen   <= 1'b0;
          csr_waddr <= '0;
          csr_wdata <= '0;
          r_state   <= ST_RESP;
          wb_valid  <= 1'b1;
          wb_data   <= r_old;
          wb_rd_idx <= r_rd_idx;
        end

        ST_RESP: begin
          if (wb_ready) begin
            r_state   <= ST_IDLE;
            ex_ready  <= 1'b1;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_rd_idx <= '0;
`ifdef CPU7_CSR_PLV_CHECK_EN
            wb_ipe    <= 1'b0;
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu7_csr_ex.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu7_csr_ex
// Description : Directed self-checking bench for cpu7_csr_ex. A small CSR
//               file model supplies combinational read data and applies
//               writes; each scenario task checks its own expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu7_csr_ex;
  import cpu7_csr_ex_pkg::*;

  localparam int RD_IDX_W = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                ex_valid = 1'b0;
  logic                ex_ready;
  logic [1:0]          ex_op = 2'b00;
  logic [CSR_BIT-1:0]  ex_csr_addr = '0;
  logic [GRLEN-1:0]    ex_wdata = '0;
  logic [GRLEN-1:0]    ex_mask = '0;
  logic [RD_IDX_W-1:0] ex_rd_idx = '0;
  logic                ex_flush = 1'b0;
  logic [CSR_BIT-1:0]  csr_raddr;
  logic [GRLEN-1:0]    csr_rdata;
  logic [CSR_BIT-1:0]  csr_waddr;
  logic [GRLEN-1:0]    csr_wdata;
  logic                csr_wen;
  logic                wb_valid;
  logic                wb_ready = 1'b1;
  logic [RD_IDX_W-1:0] wb_rd_idx;
  logic [GRLEN-1:0]    wb_data;
`ifdef CPU7_CSR_PLV_CHECK_EN
  logic [1:0]          csr_plv = 2'd0;
  logic                wb_ipe;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // CSR file model: 16 entries indexed by the low address bits.
  logic [GRLEN-1:0] mem [0:15];
  logic             load_req = 1'b0;
  logic [3:0]       load_addr = '0;
  logic [GRLEN-1:0] load_val = '0;
  int               wen_count = 0;

  assign csr_rdata = mem[csr_raddr[3:0]];

  always @(posedge clk) begin
    if (csr_wen) begin
      mem[csr_waddr[3:0]] <= csr_wdata;
      wen_count <= wen_count + 1;
    end else if (load_req) begin
      mem[load_addr] <= load_val;
    end
  end

  always #5 clk = ~clk;

  cpu7_csr_ex #(.RD_IDX_W(RD_IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_op       (ex_op),
    .ex_csr_addr (ex_csr_addr),
    .ex_wdata    (ex_wdata),
    .ex_mask     (ex_mask),
    .ex_rd_idx   (ex_rd_idx),
    .ex_flush    (ex_flush),
`ifdef CPU7_CSR_PLV_CHECK_EN
    .csr_plv     (csr_plv),
    .wb_ipe      (wb_ipe),
`endif
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .csr_wen     (csr_wen),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd_idx   (wb_rd_idx),
    .wb_data     (wb_data)
  );

  // Write a value into the CSR model (takes one cycle).
  task automatic preload(input logic [CSR_BIT-1:0] addr, input logic [GRLEN-1:0] val);
    @(negedge clk);
    load_req  = 1'b1;
    load_addr = addr[3:0];
    load_val  = val;
    @(negedge clk);
    load_req  = 1'b0;
  endtask

  // Offer one op for a single cycle; returns at the negedge of cycle N+1.
  task automatic issue(input logic [1:0] op, input logic [CSR_BIT-1:0] addr,
                       input logic [GRLEN-1:0] wd, input logic [GRLEN-1:0] mk,
                       input logic [RD_IDX_W-1:0] idx);
    @(negedge clk);
    ex_valid    = 1'b1;
    ex_op       = op;
    ex_csr_addr = addr;
    ex_wdata    = wd;
    ex_mask     = mk;
    ex_rd_idx   = idx;
    @(negedge clk);
    ex_valid    = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({ex_ready, wb_valid, csr_wen} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/valid/wen got %b want 100", {ex_ready, wb_valid, csr_wen});
    end
    n_cmp++;
    if ({csr_raddr, csr_waddr, csr_wdata, wb_data, wb_rd_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: raddr %h waddr %h wdata %h wb_data %h idx %h want all 0",
               csr_raddr, csr_waddr, csr_wdata, wb_data, wb_rd_idx);
    end
  endtask

  task automatic test_rd(input logic [1:0] op, input string nm);
    int w0;
    preload(CSR_EBASE, 32'h1C00_0000);
    w0 = wen_count;
    issue(op, CSR_EBASE, 32'hFFFF_FFFF, 32'h0, 5'd3);
    n_cmp++;
    if (csr_raddr !== CSR_EBASE || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_read: raddr %h ready %b valid %b want %h 0 0", nm, csr_raddr, ex_ready, wb_valid, CSR_EBASE);
    end
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h1C00_0000 || wb_rd_idx !== 5'd3) begin
      n_fail++;
      $display("FAIL %s_resp: valid %b data %h idx %0d want 1 1c000000 3", nm, wb_valid, wb_data, wb_rd_idx);
    end
    @(negedge clk);
    n_cmp++;
    if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || wen_count !== w0) begin
      n_fail++;
      $display("FAIL %s_done: ready %b valid %b wen %0d want 1 0 %0d", nm, ex_ready, wb_valid, wen_count, w0);
    end
  endtask

  task automatic test_wr;
    int w0;
    preload(CSR_EPC, 32'h0000_1234);
    w0 = wen_count;
    issue(2'b01, CSR_EPC, 32'hDEAD_BEEF, 32'h0, 5'd7);
    @(negedge clk);
    n_cmp++;
    if (csr_wen !== 1'b1 || csr_waddr !== CSR_EPC || csr_wdata !== 32'hDEAD_BEEF || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_write: wen %b waddr %h wdata %h valid %b want 1 006 deadbeef 0",
               csr_wen, csr_waddr, csr_wdata, wb_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_1234 || wb_rd_idx !== 5'd7 || csr_wen !== 1'b0 || csr_wdata !== '0) begin
      n_fail++;
      $display("FAIL wr_resp: valid %b data %h idx %0d wen %b wdata %h want 1 00001234 7 0 0",
               wb_valid, wb_data, wb_rd_idx, csr_wen, csr_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (mem[6] !== 32'hDEAD_BEEF || wen_count !== w0 + 1) begin
      n_fail++;
      $display("FAIL wr_commit: csr %h wen pulses %0d want deadbeef %0d", mem[6], wen_count - w0, 1);
    end
  endtask

  task automatic test_xchg;
    preload(CSR_CRMD, 32'h0000_0007);
    issue(2'b10, CSR_CRMD, 32'h0000_0000, 32'h0000_0004, 5'd1);
    @(negedge clk);
    n_cmp++;
    if (csr_wen !== 1'b1 || csr_wdata !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL xchg_write: wen %b wdata %h want 1 00000003", csr_wen, csr_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0007 || wb_rd_idx !== 5'd1) begin
      n_fail++;
      $display("FAIL xchg_resp: valid %b data %h idx %0d want 1 00000007 1", wb_valid, wb_data, wb_rd_idx);
    end
    @(negedge clk);
    n_cmp++;
    if (mem[0] !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL xchg_commit: csr %h want 00000003", mem[0]);
    end
  endtask

  task automatic test_backpressure;
    int w0;
    preload(CSR_EPC, 32'h0000_A5A5);
    w0 = wen_count;
    wb_ready = 1'b0;
    issue(2'b01, CSR_EPC, 32'h0000_1111, 32'h0, 5'd9);
    @(negedge clk); // WRITE
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h0000_A5A5 || wb_rd_idx !== 5'd9 || ex_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid %b data %h idx %0d ready %b want 1 0000a5a5 9 0",
                 i, wb_valid, wb_data, wb_rd_idx, ex_ready);
      end
    end
    wb_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || wen_count !== w0 + 1) begin
      n_fail++;
      $display("FAIL bp_release: valid %b ready %b wen pulses %0d want 0 1 1", wb_valid, ex_ready, wen_count - w0);
    end
  endtask

  task automatic test_flush;
    int w0;
    // Flush offered together with the op: not accepted.
    @(negedge clk);
    ex_valid = 1'b1; ex_flush = 1'b1; ex_op = 2'b00; ex_csr_addr = CSR_EPC;
    @(negedge clk);
    ex_valid = 1'b0; ex_flush = 1'b0;
    n_cmp++;
    if (ex_ready !== 1'b1 || csr_raddr !== '0) begin
      n_fail++;
      $display("FAIL flush_accept: ready %b raddr %h want 1 000", ex_ready, csr_raddr);
    end
    // Flush in READ: abandoned, no write.
    preload(CSR_EPC, 32'h0000_5555);
    w0 = wen_count;
    issue(2'b01, CSR_EPC, 32'h0000_9999, 32'h0, 5'd2);
    ex_flush = 1'b1;
    @(negedge clk);
    ex_flush = 1'b0;
    n_cmp++;
    if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || csr_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_read: ready %b valid %b wen %b want 1 0 0", ex_ready, wb_valid, csr_wen);
    end
    @(negedge clk);
    n_cmp++;
    if (wen_count !== w0 || mem[6] !== 32'h0000_5555 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_read_nowr: wen pulses %0d csr %h valid %b want 0 00005555 0", wen_count - w0, mem[6], wb_valid);
    end
    // Flush in WRITE: write and response still happen.
    issue(2'b01, CSR_EPC, 32'h0000_9999, 32'h0, 5'd4);
    @(negedge clk);
    ex_flush = 1'b1;
    n_cmp++;
    if (csr_wen !== 1'b1 || csr_wdata !== 32'h0000_9999) begin
      n_fail++;
      $display("FAIL flush_write_wen: wen %b wdata %h want 1 00009999", csr_wen, csr_wdata);
    end
    @(negedge clk);
    ex_flush = 1'b0;
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_5555 || wb_rd_idx !== 5'd4) begin
      n_fail++;
      $display("FAIL flush_write_resp: valid %b data %h idx %0d want 1 00005555 4", wb_valid, wb_data, wb_rd_idx);
    end
    @(negedge clk);
    n_cmp++;
    if (mem[6] !== 32'h0000_9999 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_write_commit: csr %h ready %b want 00009999 1", mem[6], ex_ready);
    end
  endtask

  task automatic test_async_reset;
    int w0;
    preload(CSR_EPC, 32'h0000_0042);
    w0 = wen_count;
    issue(2'b01, CSR_EPC, 32'hCAFE_0000, 32'h0, 5'd6);
    @(negedge clk);
    n_cmp++;
    if (csr_wen !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: wen %b want 1", csr_wen);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (csr_wen !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1 || csr_waddr !== '0) begin
      n_fail++;
      $display("FAIL arst_drop: wen %b valid %b ready %b waddr %h want 0 0 1 000", csr_wen, wb_valid, ex_ready, csr_waddr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (wen_count !== w0 || mem[6] !== 32'h0000_0042 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_after: wen pulses %0d csr %h valid %b ready %b want 0 00000042 0 1",
               wen_count - w0, mem[6], wb_valid, ex_ready);
    end
  endtask

`ifdef CPU7_CSR_PLV_CHECK_EN
  task automatic test_plv;
    int w0;
    preload(CSR_EPC, 32'h0000_0077);
    w0 = wen_count;
    csr_plv = 2'd3;
    issue(2'b01, CSR_EPC, 32'h1234_5678, 32'h0, 5'd8);
    csr_plv = 2'd0;
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_ipe !== 1'b1 || wb_data !== '0 || wb_rd_idx !== 5'd8 || csr_raddr !== '0) begin
      n_fail++;
      $display("FAIL plv_resp: valid %b ipe %b data %h idx %0d raddr %h want 1 1 0 8 000",
               wb_valid, wb_ipe, wb_data, wb_rd_idx, csr_raddr);
    end
    @(negedge clk);
    n_cmp++;
    if (wen_count !== w0 || mem[6] !== 32'h0000_0077 || wb_ipe !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL plv_done: wen pulses %0d csr %h ipe %b ready %b want 0 00000077 0 1",
               wen_count - w0, mem[6], wb_ipe, ex_ready);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_rd(2'b00, "rd");
    test_wr();
    test_xchg();
    test_backpressure();
    test_flush();
    test_rd(2'b11, "rsvd");
    test_async_reset();
`ifdef CPU7_CSR_PLV_CHECK_EN
    test_plv();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
